// File: rtl/fpnew_pkg.sv
// Shared FPU types: rounding-mode encoding and dynamic-mode resolution against the CSR frm.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  localparam int unsigned ROUND_MODE_W = 3;

  // Returns {illegal, mode}; illegal encodings collapse to RNE so the datapath never sees them.
  function automatic logic [ROUND_MODE_W:0] resolve_rm(input logic [ROUND_MODE_W-1:0] mode,
                                                       input logic [ROUND_MODE_W-1:0] frm);
    logic [ROUND_MODE_W-1:0] eff;
    eff = (mode == DYN) ? frm : mode;
    if (eff == ROD || eff == 3'b110 || eff == DYN) return {1'b1, RNE};
    return {1'b0, eff};
  endfunction

endpackage

// File: rtl/fpnew_rounding.sv
// Magnitude rounding from round/sticky bits; sign fix-up for exact-zero effective subtractions.
module fpnew_rounding
  import fpnew_pkg::*;
#(
  parameter int unsigned AbsWidth = 31
) (
  input  logic [AbsWidth-1:0] abs_value,
  input  logic                sign,
  input  logic [1:0]          round_sticky,
  input  roundmode_e          rnd_mode,
  input  logic                effective_subtraction,
  output logic [AbsWidth-1:0] abs_rounded,
  output logic                sign_rounded,
  output logic                exact_zero
);

  logic round_up;

  always_comb begin
    round_up = 1'b0;
    case (rnd_mode)
      RNE: begin
        case (round_sticky)
          2'b10:   round_up = abs_value[0];
          2'b11:   round_up = 1'b1;
          default: round_up = 1'b0;
        endcase
      end
      RDN:     round_up = (|round_sticky) & sign;
      RUP:     round_up = (|round_sticky) & ~sign;
      RMM:     round_up = round_sticky[1];
      default: round_up = 1'b0;
    endcase
  end

  // Carry out of the all-ones magnitude is dropped; the exponent bump is handled upstream.
  assign abs_rounded  = abs_value + AbsWidth'(round_up);
  assign exact_zero   = (abs_value == '0) && (round_sticky == 2'b00);
  assign sign_rounded = (exact_zero && effective_subtraction) ? (rnd_mode == RDN) : sign;

endmodule

// File: rtl/fpnew_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner.
module fpnew_rr_arbiter #(
  parameter  int unsigned NumReq  = 4,
  localparam int unsigned IdWidth = $clog2(NumReq)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NumReq-1:0]  req,
  input  logic               en,
  output logic [NumReq-1:0]  gnt,
  output logic [IdWidth-1:0] idx,
  output logic               gnt_vld
);

  logic [IdWidth-1:0] ptr;
  int unsigned        cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    if (en) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = (32'(ptr) + k) % NumReq;
        if (!gnt_vld && req[cand]) begin
          gnt_vld   = 1'b1;
          idx       = IdWidth'(cand);
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (gnt_vld) ptr <= (idx == IdWidth'(NumReq - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/fpnew_round_arbiter.sv
// Shares one rounding datapath between NumReq FP lanes: RR grant, mode resolution, 2-stage pipe.
module fpnew_round_arbiter
  import fpnew_pkg::*;
#(
  parameter  int unsigned NumReq   = 4,
  parameter  int unsigned AbsWidth = 31,
  localparam int unsigned IdWidth  = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*AbsWidth-1:0]   req_abs_i,
  input  logic [NumReq-1:0]            req_sign_i,
  input  logic [NumReq*2-1:0]          req_rs_i,
  input  logic [NumReq*3-1:0]          req_mode_i,
  input  logic [NumReq-1:0]            req_effsub_i,
  input  logic [2:0]                   frm_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [IdWidth-1:0]           out_id_o,
  output logic [AbsWidth-1:0]          out_abs_o,
  output logic                         out_sign_o,
  output logic                         out_zero_o,
  output logic                         out_inexact_o,
  output logic                         out_illegal_o
);

  if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
    $error("fpnew_round_arbiter: NumReq must be in 2..8");
  end

  logic                    vld_p1, illegal_p1, sign_p1, effsub_p1;
  logic [AbsWidth-1:0]     abs_p1;
  logic [1:0]              rs_p1;
  roundmode_e              mode_p1;
  logic [IdWidth-1:0]      id_p1;
  logic                    s1_load, s2_load, arb_en, gnt_vld;
  logic [IdWidth-1:0]      gnt_idx;
  logic [ROUND_MODE_W:0]   rm_res;
  logic [AbsWidth-1:0]     rnd_abs;
  logic                    rnd_sign, rnd_zero;

  assign s2_load = !out_valid_o || out_ready_i;
  assign s1_load = !vld_p1 || s2_load;
  assign arb_en  = s1_load && !flush_i && !rst_i;

  fpnew_rr_arbiter #(.NumReq(NumReq)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_valid_i),
    .en      (arb_en),
    .gnt     (req_ready_o),
    .idx     (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign rm_res = resolve_rm(req_mode_i[32'(gnt_idx)*ROUND_MODE_W +: ROUND_MODE_W], frm_i);

  // Stage S1: registered winner operand with its resolved mode
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) vld_p1 <= 1'b0;
    else if (s1_load)     vld_p1 <= gnt_vld;
  end

  always_ff @(posedge clk_i) begin
    if (gnt_vld) begin
      abs_p1     <= req_abs_i[32'(gnt_idx)*AbsWidth +: AbsWidth];
      sign_p1    <= req_sign_i[gnt_idx];
      rs_p1      <= req_rs_i[32'(gnt_idx)*2 +: 2];
      effsub_p1  <= req_effsub_i[gnt_idx];
      mode_p1    <= roundmode_e'(rm_res[ROUND_MODE_W-1:0]);
      illegal_p1 <= rm_res[ROUND_MODE_W];
      id_p1      <= gnt_idx;
    end
  end

  fpnew_rounding #(.AbsWidth(AbsWidth)) u_round (
    .abs_value             (abs_p1),
    .sign                  (sign_p1),
    .round_sticky          (rs_p1),
    .rnd_mode              (mode_p1),
    .effective_subtraction (effsub_p1),
    .abs_rounded           (rnd_abs),
    .sign_rounded          (rnd_sign),
    .exact_zero            (rnd_zero)
  );

  // Stage S2: output register, held while downstream stalls
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) out_valid_o <= 1'b0;
    else if (s2_load)     out_valid_o <= vld_p1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_id_o      <= '0;
      out_abs_o     <= '0;
      out_sign_o    <= 1'b0;
      out_zero_o    <= 1'b0;
      out_inexact_o <= 1'b0;
      out_illegal_o <= 1'b0;
    end else if (s2_load && vld_p1) begin
      out_id_o      <= id_p1;
      out_abs_o     <= rnd_abs;
      out_sign_o    <= rnd_sign;
      out_zero_o    <= rnd_zero;
      out_inexact_o <= |rs_p1;
      out_illegal_o <= illegal_p1;
    end
  end

endmodule

// File: tb/tb_fpnew_round_arbiter.sv
// Directed bench for fpnew_round_arbiter: behavioural scoreboard checked every cycle plus literal checks.
module tb_fpnew_round_arbiter;
  localparam int N = 4;
  localparam int W = 31;

  logic           clk = 1'b0;
  logic           rst, flush, out_ready;
  logic [N-1:0]   req_valid, req_ready, req_sign, req_effsub;
  logic [N*W-1:0] req_abs;
  logic [N*2-1:0] req_rs;
  logic [N*3-1:0] req_mode;
  logic [2:0]     frm;
  logic           out_valid, out_sign, out_zero, out_inexact, out_illegal;
  logic [1:0]     out_id;
  logic [W-1:0]   out_abs;

  logic [W-1:0] p_abs[N];
  logic         p_sign[N], p_effsub[N];
  logic [1:0]   p_rs[N];
  logic [2:0]   p_mode[N];

  always #5 clk = ~clk;

  always_comb begin
    req_abs = '0; req_rs = '0; req_mode = '0; req_sign = '0; req_effsub = '0;
    for (int i = 0; i < N; i++) begin
      req_abs[i*W +: W]  = p_abs[i];
      req_rs[i*2 +: 2]   = p_rs[i];
      req_mode[i*3 +: 3] = p_mode[i];
      req_sign[i]        = p_sign[i];
      req_effsub[i]      = p_effsub[i];
    end
  end

  fpnew_round_arbiter #(.NumReq(N), .AbsWidth(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_abs_i(req_abs), .req_sign_i(req_sign), .req_rs_i(req_rs), .req_mode_i(req_mode),
    .req_effsub_i(req_effsub), .frm_i(frm), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_id_o(out_id), .out_abs_o(out_abs), .out_sign_o(out_sign),
    .out_zero_o(out_zero), .out_inexact_o(out_inexact), .out_illegal_o(out_illegal)
  );

  typedef struct {
    int         t;
    logic [1:0] id;
    logic [W-1:0] abs;
    logic       sign, zero, inexact, illegal;
  } exp_t;

  int   vectors = 0, miscompares = 0;
  exp_t q[$];
  int   glog[$], olog[$];
  int   pops = 0, mptr = 0, cyc = 0;
  logic [W-1:0] last_abs;
  logic last_sign, last_zero, last_inexact, last_illegal;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected result from the rounding rules on the operand currently presented by requester i.
  function automatic exp_t model(input int i, input int t);
    exp_t e;
    int   md, qv;
    logic up;
    md = (p_mode[i] == 3'd7) ? int'(frm) : int'(p_mode[i]);
    e.illegal = (md >= 5);
    if (md >= 5) md = 0;
    qv = int'(p_rs[i]);
    case (md)
      0:       up = (qv == 3) || (qv == 2 && p_abs[i][0]);
      1:       up = 1'b0;
      2:       up = (qv != 0) && p_sign[i];
      3:       up = (qv != 0) && !p_sign[i];
      default: up = (qv >= 2);
    endcase
    e.abs     = p_abs[i] + W'(up);
    e.zero    = (p_abs[i] == '0) && (qv == 0);
    e.sign    = (e.zero && p_effsub[i]) ? (md == 2) : p_sign[i];
    e.inexact = (qv != 0);
    e.id      = 2'(i);
    e.t       = t;
    return e;
  endfunction

  logic        prev_stall = 1'b0;
  logic [63:0] prev_out;

  always @(negedge clk) begin
    int          gi;
    logic [N-1:0] exp_gnt;
    logic        exp_ov;
    logic [63:0] cur_out;
    gi = -1;
    if (!rst && !flush && (q.size() < 2 || out_ready))
      for (int k = 0; k < N; k++)
        if (gi < 0 && req_valid[(mptr + k) % N]) gi = (mptr + k) % N;
    exp_gnt = (gi >= 0) ? N'(1 << gi) : '0;
    chk("req_ready", req_ready, exp_gnt);
    exp_ov = (q.size() > 0) && (cyc - q[0].t >= 2);
    chk("out_valid", out_valid, exp_ov);
    cur_out = {27'd0, out_id, out_abs, out_sign, out_zero, out_inexact, out_illegal};
    if (out_valid && exp_ov)
      chk("out_payload", cur_out,
          {27'd0, q[0].id, q[0].abs, q[0].sign, q[0].zero, q[0].inexact, q[0].illegal});
    if (prev_stall) chk("stall_stable", cur_out, prev_out);
    prev_stall = out_valid && !out_ready && !rst && !flush;
    prev_out   = cur_out;
    if (out_valid && out_ready && q.size() > 0) begin
      olog.push_back(int'(out_id));
      last_abs = out_abs; last_sign = out_sign; last_zero = out_zero;
      last_inexact = out_inexact; last_illegal = out_illegal;
      void'(q.pop_front());
      pops++;
    end
    if (rst) begin
      q.delete(); mptr = 0;
    end else if (flush) begin
      q.delete();
    end else if (gi >= 0) begin
      q.push_back(model(gi, cyc));
      glog.push_back(gi);
      mptr = (gi + 1) % N;
    end
    cyc++;
  end

  task automatic issue(input int i);
    int k;
    req_valid[i] = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk("issue_grant", (k < 50), 1'b1);
  endtask

  task automatic wait_pops(input int target, input string nm);
    for (int k = 0; k < 50 && pops < target; k++) @(posedge clk);
    #1;
    chk(nm, (pops >= target), 1'b1);
  endtask

  initial begin
    int p0, g0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; frm = 3'd0; req_valid = '0;
    for (int i = 0; i < N; i++) begin
      p_abs[i] = W'(16 * i + 1 + i % 2); p_sign[i] = i[0]; p_rs[i] = 2'(i);
      p_mode[i] = 3'(i); p_effsub[i] = 1'b0;
    end
    @(posedge clk); #1;
    chk("rst_out", {out_valid, out_id, out_abs, out_sign, out_zero, out_inexact, out_illegal}, 0);
    chk("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_out", {out_valid, out_id, out_abs, out_sign, out_zero, out_inexact, out_illegal}, 0);
      chk("idle_ready", req_ready, 0);
    end

    // Back-to-back grants from a freshly reset pointer
    g0 = glog.size();
    req_valid = 4'hF;
    repeat (5) @(posedge clk); #1 req_valid = '0;
    chk("rr_count", glog.size() - g0, 5);
    for (int i = 0; i < 5; i++) chk("rr_order", glog[g0 + i], i % 4);
    wait_pops(5, "rr_drain");
    for (int i = 0; i < 5; i++) chk("rr_out_id", olog[i], i % 4);

    // DYN with frm=RNE, then DYN with an illegal frm (falls back to RNE: tie on odd 5 -> 6)
    p_abs[2] = 31'd5; p_rs[2] = 2'b10; p_mode[2] = 3'b111; p_sign[2] = 1'b0; p_effsub[2] = 1'b0;
    frm = 3'b000; p0 = pops;
    issue(2); wait_pops(p0 + 1, "dyn_rne_wait");
    chk("dyn_rne_abs", last_abs, 31'd6);
    chk("dyn_rne_flags", {last_inexact, last_illegal}, 2'b10);
    chk("dyn_rne_id", olog[olog.size() - 1], 2);
    frm = 3'b101; p0 = pops;
    issue(2); wait_pops(p0 + 1, "dyn_ill_wait");
    chk("dyn_ill_abs", last_abs, 31'd6);
    chk("dyn_ill_flag", last_illegal, 1'b1);
    frm = 3'b000;

    // All-ones magnitude wraps under RUP; exact zero of an effective subtraction under RDN
    p_abs[1] = 31'h7FFF_FFFF; p_rs[1] = 2'b11; p_mode[1] = 3'b011; p_sign[1] = 1'b0; p_effsub[1] = 1'b0;
    p0 = pops;
    issue(1); wait_pops(p0 + 1, "wrap_wait");
    chk("wrap_abs", last_abs, 31'd0);
    chk("wrap_zero_inexact", {last_zero, last_inexact}, 2'b01);
    p_abs[3] = 31'd0; p_rs[3] = 2'b00; p_mode[3] = 3'b010; p_sign[3] = 1'b0; p_effsub[3] = 1'b1;
    p0 = pops;
    issue(3); wait_pops(p0 + 1, "zero_wait");
    chk("zero_sign_zero", {last_sign, last_zero, last_inexact}, 3'b110);

    // Downstream stall with two requesters: pipeline fills once, then order is preserved
    g0 = glog.size(); p0 = pops;
    out_ready = 1'b0; req_valid = 4'b0011;
    repeat (5) @(posedge clk); #1;
    chk("stall_grants", glog.size() - g0, 2);
    req_valid = '0; out_ready = 1'b1;
    wait_pops(p0 + 2, "stall_drain");
    chk("stall_order0", olog[olog.size() - 2], 0);
    chk("stall_order1", olog[olog.size() - 1], 1);

    // Flush with both stages full; pointer continues where it was
    g0 = glog.size();
    out_ready = 1'b0; req_valid = 4'hF;
    repeat (3) @(posedge clk); #1;
    chk("pre_flush_grants", glog.size() - g0, 2);
    chk("pre_flush_last", glog[glog.size() - 1], 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_no_grant", glog.size() - g0, 2);
    @(posedge clk); #1 req_valid = '0;
    chk("flush_resume", glog[glog.size() - 1], 0);
    repeat (4) @(posedge clk);

    // Reset mid-flight drops the operation and returns the pointer to 0
    #1; p0 = pops;
    req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("rst_drop", pops, p0);
    chk("rst_drop_valid", out_valid, 1'b0);
    req_valid = 4'hF;
    @(posedge clk); #1 req_valid = '0;
    chk("rst_ptr", glog[glog.size() - 1], 0);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
